// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    localparam int SA_MAX_WIDTH = 32;

endpackage

// File: rtl/half_adder_cell.sv
// Half-adder cell: one-bit sum and carry of two inputs.
module half_adder_cell (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/serial_adder_fa.sv
// Full-adder cell made from two half-adder cells and an OR gate on the carries.
module full_adder_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic z,
    output logic co
);

    logic s1, c1, c2;

    half_adder_cell ha0 (
        .x (x),
        .y (y),
        .s (s1),
        .c (c1)
    );

    half_adder_cell ha1 (
        .x (s1),
        .y (ci),
        .s (z),
        .c (c2)
    );

    assign co = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder with valid/ready handshakes on both sides.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input for a - b.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sa_state_t        state, next_state;
    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_z, fa_co;
    logic             accept;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);
    assign accept    = in_valid && in_ready;

    full_adder_cell fa (
        .x  (sa[0]),
        .y  (sb[0]),
        .ci (carry),
        .z  (fa_z),
        .co (fa_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = RUN;
            RUN:     if (cnt == LAST) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1, so the inversion and the +1 carry-in happen at load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa    <= '0;
            sb    <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sa  <= a;
                        cnt <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                        sb    <= sub ? ~b : b;
                        carry <= sub;
`else
                        sb    <= b;
                        carry <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    carry <= fa_co;
                    sum   <= {fa_z, sum[WIDTH-1:1]};
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cout <= fa_co;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
